// File: rtl/timer_ctrl.sv
// Command-driven programmable timer: prescaled up-counter with a terminal limit.
// It supports one-shot and periodic modes and emits a one-cycle done pulse on each terminal event.
//
//   state | meaning
//   IDLE  | stopped, count and prescaler cleared
//   RUN   | prescaler advancing, count steps on each tick
//   PAUSE | stopped, count and prescaler frozen
//   DONE  | one-shot run reached its terminal event
module timer_ctrl #(
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [WIDTH-1:0]      cmd_data,
    input  logic                  periodic,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic [WIDTH-1:0]      count,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10,
        S_DONE  = 2'b11
    } state_t;

    localparam logic [1:0] OP_START = 2'b00;
    localparam logic [1:0] OP_STOP  = 2'b01;
    localparam logic [1:0] OP_LOAD  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    state_t                  state_q;
    logic [WIDTH-1:0]        count_q;
    logic [WIDTH-1:0]        limit_q;
    logic [PRESCALE_W-1:0]   presc_q;
    logic                    done_q;
    logic                    busy_q;
    logic                    ready_q;

    logic accept;
    logic tick;
    logic terminal;

    // Both compares use >= so that a shrinking prescale or limit takes effect at once.
    assign accept   = cmd_valid && ready_q;
    assign tick     = (state_q == S_RUN) && (presc_q >= prescale);
    assign terminal = tick && (count_q >= limit_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            count_q <= '0;
            limit_q <= '1;
            presc_q <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            ready_q <= !accept;
            done_q  <= 1'b0;
            if (accept && cmd_op == OP_LOAD) begin
                limit_q <= cmd_data;
            end
            // STOP and CLEAR take priority over a coincident tick; an ignored command lets it proceed.
            if (accept && cmd_op == OP_CLEAR) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
                count_q <= '0;
                presc_q <= '0;
            end else if (accept && cmd_op == OP_STOP && state_q == S_RUN) begin
                state_q <= S_PAUSE;
                busy_q  <= 1'b0;
            end else if (accept && cmd_op == OP_START && state_q != S_RUN) begin
                state_q <= S_RUN;
                busy_q  <= 1'b1;
                if (state_q != S_PAUSE) begin
                    count_q <= '0;
                    presc_q <= '0;
                end
            end else if (state_q == S_RUN) begin
                if (tick) begin
                    presc_q <= '0;
                    if (terminal) begin
                        count_q <= '0;
                        done_q  <= 1'b1;
                        if (!periodic) begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        count_q <= count_q + 1'b1;
                    end
                end else begin
                    presc_q <= presc_q + 1'b1;
                end
            end
        end
    end

    assign cmd_ready = ready_q;
    assign count     = count_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign state     = state_q;

endmodule

// File: doc/timer_ctrl.md
Name: timer_ctrl

Overview:
Command-driven controller that sequences a free-running up-counter into a programmable timer. It adds a clock prescaler, a programmable terminal limit, one-shot and periodic modes, and start/stop/load/clear commands over a valid/ready handshake. It emits a one-cycle done pulse on each terminal event. It sits between a host/sequencer and any logic that needs timed events, such as LED blink rates or sample strobes.

Parameters:
WIDTH, 8, width of count and limit
PRESCALE_W, 8, width of prescale input and internal prescaler

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-low reset (asserts when 0)
cmd_valid  input  1  command present
cmd_ready  output  1  controller can accept a command this cycle
cmd_op  input  2  00 START, 01 STOP, 10 LOAD, 11 CLEAR
cmd_data  input  WIDTH  new limit, used by LOAD only
periodic  input  1  1 = auto-restart at terminal, 0 = one-shot
prescale  input  PRESCALE_W  count advances every prescale+1 clocks
count  output  WIDTH  current count value (registered)
busy  output  1  high in RUN
done  output  1  one-cycle pulse on terminal event
state  output  2  00 IDLE, 01 RUN, 10 PAUSE, 11 DONE

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, count=0, limit=all-ones, prescaler=0.
  - done=0, busy=0, cmd_ready=1.
- Handshake:
  - A command is accepted when cmd_valid && cmd_ready at a clock edge.
  - cmd_ready drops to 0 for exactly the one cycle after an accepted command, then returns to 1; minimum command spacing is 2 cycles.
  - cmd_op/cmd_data are ignored unless accepted.
- Prescaler and tick:
  - In RUN only, the prescaler increments each cycle.
  - When prescaler >= prescale, tick=1 that cycle and the prescaler returns to 0.
  - prescale=0 gives a tick every cycle.
  - The >= compare makes a mid-run decrease of prescale take effect immediately, with no hang.
- Terminal event:
  - On a tick with count >= limit: count<=0 and done pulses for 1 cycle.
  - periodic=1: remain in RUN. periodic=0: go to DONE, busy<=0.
  - On any other tick: count<=count+1.
  - Period = (limit+1)*(prescale+1) clocks.
  - The >= compare means a LOAD below the current count terminates on the next tick.
- Commands:
  - START: IDLE or DONE -> RUN with count=0, prescaler=0. PAUSE -> RUN, count and prescaler retained. Ignored in RUN.
  - STOP: RUN -> PAUSE, count and prescaler frozen. Ignored elsewhere.
  - LOAD: limit<=cmd_data in any state; no state change.
  - CLEAR: any state -> IDLE, count=0, prescaler=0; limit retained.
- Simultaneous events (command accepted in the same cycle as a tick):
  - STOP or CLEAR wins: the tick is discarded, with no increment and no done.
  - START in RUN is ignored and the tick proceeds normally.
  - LOAD: the tick evaluates the old limit; the new limit applies from the next cycle.
- Other rules:
  - done never asserts outside a tick cycle in RUN; it is never high for 2 consecutive cycles unless limit=0 and prescale=0 in periodic mode, where it is continuously high.
  - count wraps only via a terminal event. It never exceeds the all-ones value because limit <= 2^WIDTH-1.
  - busy = (state==RUN), registered with state.
  - Reset mid-operation returns everything to reset values immediately, independent of clk.
  - A pending done pulse is cleared by reset.

Test Plan:
- Reset then LOAD 3, periodic=0, prescale=0, START -> count 0,1,2,3 on successive cycles; done pulses once on the cycle count returns to 0; state=DONE, busy=0.
- LOAD 2, periodic=1, prescale=3, START -> count increments every 4 clocks; done pulses every 12 clocks; runs for 5 periods without gaps.
- Running with limit=10, STOP at count=5 -> count holds 5 for 20 cycles, state=PAUSE; START -> resumes 6,7,... with no done before count=10 terminal.
- At count=5 in RUN, LOAD 2 -> next tick terminates: done pulse, count=0. Separately, STOP issued on a terminal tick cycle -> no done, count unchanged, state=PAUSE.
- Back-to-back cmd_valid held high -> cmd_ready toggles 1,0,1,0; only alternate cycles are accepted. CLEAR while RUN -> state IDLE, count 0, limit unchanged (verified by a later START).
- Assert rst=0 asynchronously between clock edges mid-RUN -> outputs go to reset values before the next edge; after release, LOAD/START behaves as from a fresh reset.
